// File: rtl/layer_stream_serializer_pkg.sv
// Shared definitions for the layer stream serializer: FSM state encoding
// and counter width helpers.
package layer_stream_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } stream_state_t;

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/layer_vec_buf.sv
// Two-bank ping-pong vector store: a whole vector is written in one cycle,
// single elements are read back through a registered port.
module layer_vec_buf
   import layer_stream_serializer_pkg::*;
#(
   parameter int numNeurons = 30,
   parameter int dataWidth  = 16,
   parameter int idxWidth   = cnt_width(numNeurons)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_en,
   input  logic                            wr_sel,
   input  logic [numNeurons*dataWidth-1:0] wr_data,
   input  logic                            rd_en,
   input  logic                            rd_sel,
   input  logic [idxWidth-1:0]             rd_idx,
   output logic [dataWidth-1:0]            rd_data
);

   logic [numNeurons*dataWidth-1:0] bank [2];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         bank[wr_sel] <= wr_data;
      end
   end

   // Read register holds its value between strobes so the output stays steady in gaps.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= bank[rd_sel][int'(rd_idx)*dataWidth +: dataWidth];
      end
   end

endmodule

// File: rtl/layer_stream_serializer.sv
// Captures a parallel activation vector in one cycle and replays it one element
// per cycle, with a fixed idle gap after every vector.
module layer_stream_serializer
   import layer_stream_serializer_pkg::*;
#(
   parameter int numNeurons     = 30,
   parameter int dataWidth      = 16,
   parameter int interVectorGap = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [numNeurons*dataWidth-1:0] x_in,
   input  logic                            x_valid,
   output logic [dataWidth-1:0]            data_out,
   output logic                            data_out_valid,
   output logic                            busy,
   output logic                            overflow
);

   localparam int idxWidth = cnt_width(numNeurons);
   localparam int gapWidth = cnt_width(interVectorGap);
   localparam logic [idxWidth-1:0] lastIdx = idxWidth'(numNeurons - 1);
   localparam logic [gapWidth-1:0] lastGap = gapWidth'(interVectorGap - 1);

   stream_state_t       state;
   logic [idxWidth-1:0] idx;
   logic [idxWidth-1:0] rd_idx;
   logic [gapWidth-1:0] gcnt;
   logic [1:0]          occ;
   logic [1:0]          occ_next;
   logic                wsel;
   logic                rsel;
   logic                release_bank;
   logic                capture;
   logic                load;
   logic                go_idle;
   logic                busy_next;

   // A full buffer still accepts on a release cycle: the last element of the
   // released bank already sits in the read register, so the bank is free.
   always_comb begin
      release_bank = (state == STREAM) && (idx == lastIdx);
      capture      = x_valid && ((occ != 2'd2) || release_bank);

      load = 1'b0;
      case (state)
         IDLE:    load = (occ != 2'd0);
         STREAM:  load = (idx != lastIdx);
         GAP:     load = (gcnt == lastGap) && (occ != 2'd0);
         default: load = 1'b0;
      endcase

      rd_idx = '0;
      if ((state == STREAM) && (idx != lastIdx)) begin
         rd_idx = idx + 1'b1;
      end

      occ_next = occ;
      if (capture && !release_bank) begin
         occ_next = occ + 2'd1;
      end else if (!capture && release_bank) begin
         occ_next = occ - 2'd1;
      end

      go_idle   = ((state == IDLE) && (occ == 2'd0)) ||
                  ((state == GAP) && (gcnt == lastGap) && (occ == 2'd0));
      busy_next = !go_idle || (occ_next != 2'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         gcnt           <= '0;
         occ            <= 2'd0;
         wsel           <= 1'b0;
         rsel           <= 1'b0;
         overflow       <= 1'b0;
         data_out_valid <= 1'b0;
         busy           <= 1'b0;
      end else begin
         occ            <= occ_next;
         busy           <= busy_next;
         data_out_valid <= load;
         if (capture) begin
            wsel <= ~wsel;
         end
         if (x_valid && !capture) begin
            overflow <= 1'b1;
         end
         if (release_bank) begin
            rsel <= ~rsel;
         end
         case (state)
            IDLE: begin
               if (occ != 2'd0) begin
                  state <= STREAM;
                  idx   <= '0;
               end
            end
            STREAM: begin
               if (idx == lastIdx) begin
                  state <= GAP;
                  idx   <= '0;
                  gcnt  <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            GAP: begin
               if (gcnt == lastGap) begin
                  gcnt  <= '0;
                  state <= (occ != 2'd0) ? STREAM : IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   layer_vec_buf #(
      .numNeurons (numNeurons),
      .dataWidth  (dataWidth),
      .idxWidth   (idxWidth)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (capture),
      .wr_sel  (wsel),
      .wr_data (x_in),
      .rd_en   (load),
      .rd_sel  (rsel),
      .rd_idx  (rd_idx),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Self-checking bench for layer_stream_serializer against a vector-level timing model.
module tb_layer_stream_serializer;

   localparam int N = 4;
   localparam int W = 16;
   localparam int G = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] x_in;
   logic           x_valid;
   logic [W-1:0]   data_out;
   logic           data_out_valid;
   logic           busy;
   logic           overflow;

   always #5 clk = ~clk;

   layer_stream_serializer #(
      .numNeurons     (N),
      .dataWidth      (W),
      .interVectorGap (G)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .x_in           (x_in),
      .x_valid        (x_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .busy           (busy),
      .overflow       (overflow)
   );

   // Each accepted vector: edge it was accepted, edge its first element is loaded, payload.
   typedef struct packed {
      int             t_acc;
      int             s;
      logic [N*W-1:0] d;
   } vec_t;

   vec_t         q[$];
   int           edge_no;
   int           next_free;
   logic [W-1:0] last_val;
   logic         ovf_m;
   logic         exp_valid;
   logic         exp_busy;
   logic [W-1:0] exp_data;
   int           tests;
   int           fails;

   // Advance one clock edge, update the model, then settle #1 for sampling.
   task automatic step();
      int   cnt;
      int   s;
      vec_t v;
      @(posedge clk);
      edge_no++;
      if (rst) begin
         q.delete();
         last_val  = '0;
         ovf_m     = 1'b0;
         next_free = 0;
      end else if (x_valid) begin
         cnt = 0;
         foreach (q[i]) if (q[i].s + N > edge_no) cnt++;
         if (cnt < 2) begin
            s = (edge_no + 1 > next_free) ? edge_no + 1 : next_free;
            v.t_acc = edge_no;
            v.s     = s;
            v.d     = x_in;
            q.push_back(v);
            next_free = s + N + G;
         end else begin
            ovf_m = 1'b1;
         end
      end
      while (q.size() > 0 && q[0].s + N + G < edge_no) void'(q.pop_front());
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      foreach (q[i]) begin
         if (edge_no >= q[i].s && edge_no < q[i].s + N) begin
            exp_valid = 1'b1;
            last_val  = q[i].d[(edge_no - q[i].s)*W +: W];
         end
         if (edge_no >= q[i].t_acc && edge_no <= q[i].s + N + G - 1) exp_busy = 1'b1;
      end
      exp_data = last_val;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      x_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 20; c++) begin
         x_in = {$urandom, $urandom};
         step();
         tests++;
         if ({data_out_valid, data_out, busy, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL reset_idle c=%0d: got v=%b d=%h busy=%b ovf=%b, want all 0",
                     c, data_out_valid, data_out, busy, overflow);
         end
      end
   endtask

   task automatic test_single_vector();
      logic [W-1:0] seq [N];
      int           strobes;
      seq = '{16'h0001, 16'h8000, 16'h7FFF, 16'h00A5};
      do_reset();
      strobes = 0;
      for (int c = 0; c < 20; c++) begin
         x_valid = (c == 0);
         x_in    = (c == 0) ? {seq[3], seq[2], seq[1], seq[0]} : {$urandom, $urandom};
         step();
         if (data_out_valid === 1'b1) strobes++;
         tests++;
         if ({data_out_valid, data_out, busy, overflow} !== {exp_valid, exp_data, exp_busy, ovf_m}) begin
            fails++;
            $display("[TB] FAIL single_model c=%0d: got v=%b d=%h busy=%b ovf=%b, want v=%b d=%h busy=%b ovf=%b",
                     c, data_out_valid, data_out, busy, overflow, exp_valid, exp_data, exp_busy, ovf_m);
         end
         tests++;
         if (data_out_valid !== (c >= 1 && c <= N) ||
             (c >= 1 && c <= N && data_out !== seq[c-1]) ||
             busy !== (c <= N + G)) begin
            fails++;
            $display("[TB] FAIL single_directed c=%0d: got v=%b d=%h busy=%b, want v=%b busy=%b",
                     c, data_out_valid, data_out, busy, (c >= 1 && c <= N), (c <= N + G));
         end
      end
      x_valid = 1'b0;
      tests++;
      if (strobes !== N) begin
         fails++;
         $display("[TB] FAIL single_strobe_count: got %0d, want %0d", strobes, N);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c < 36; c++) begin
         x_valid = (c == 0) || (c == 3);
         x_in    = (c == 0) ? {N{16'h1111}} : (c == 3) ? {N{16'h2222}} : {$urandom, $urandom};
         step();
         tests++;
         if ({data_out_valid, data_out, busy, overflow} !== {exp_valid, exp_data, exp_busy, ovf_m}) begin
            fails++;
            $display("[TB] FAIL back_to_back c=%0d: got v=%b d=%h busy=%b ovf=%b, want v=%b d=%h busy=%b ovf=%b",
                     c, data_out_valid, data_out, busy, overflow, exp_valid, exp_data, exp_busy, ovf_m);
         end
      end
      x_valid = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int c = 0; c < 40; c++) begin
         x_valid = (c <= 2);
         x_in    = {$urandom, $urandom};
         step();
         tests++;
         if ({data_out_valid, data_out, busy, overflow} !== {exp_valid, exp_data, exp_busy, ovf_m} ||
             overflow !== (c >= 2)) begin
            fails++;
            $display("[TB] FAIL overflow c=%0d: got v=%b d=%h busy=%b ovf=%b, want v=%b d=%h busy=%b ovf=%b",
                     c, data_out_valid, data_out, busy, overflow, exp_valid, exp_data, exp_busy, ovf_m);
         end
      end
      x_valid = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int c = 0; c < 45; c++) begin
         x_valid = (c == 0) || (c == 1) || (c == N + 1);
         x_in    = {$urandom, $urandom};
         step();
         tests++;
         if ({data_out_valid, data_out, busy, overflow} !== {exp_valid, exp_data, exp_busy, ovf_m} ||
             overflow !== 1'b0) begin
            fails++;
            $display("[TB] FAIL simultaneous c=%0d: got v=%b d=%h busy=%b ovf=%b, want v=%b d=%h busy=%b ovf=0",
                     c, data_out_valid, data_out, busy, overflow, exp_valid, exp_data, exp_busy);
         end
      end
      x_valid = 1'b0;
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      for (int c = 0; c < 30; c++) begin
         rst     = (c == 3);
         x_valid = (c == 0) || (c == 5);
         x_in    = {$urandom, $urandom};
         step();
         tests++;
         if ({data_out_valid, data_out, busy, overflow} !== {exp_valid, exp_data, exp_busy, ovf_m} ||
             (c == 3 && data_out_valid !== 1'b0)) begin
            fails++;
            $display("[TB] FAIL reset_mid_stream c=%0d: got v=%b d=%h busy=%b ovf=%b, want v=%b d=%h busy=%b ovf=%b",
                     c, data_out_valid, data_out, busy, overflow, exp_valid, exp_data, exp_busy, ovf_m);
         end
      end
      rst     = 1'b0;
      x_valid = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         x_valid = ($urandom_range(0, 9) == 0);
         x_in    = {$urandom, $urandom};
         step();
         tests++;
         if ({data_out_valid, data_out, busy, overflow} !== {exp_valid, exp_data, exp_busy, ovf_m}) begin
            fails++;
            $display("[TB] FAIL random c=%0d: got v=%b d=%h busy=%b ovf=%b, want v=%b d=%h busy=%b ovf=%b",
                     c, data_out_valid, data_out, busy, overflow, exp_valid, exp_data, exp_busy, ovf_m);
         end
      end
      x_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      x_valid   = 1'b0;
      x_in      = '0;
      tests     = 0;
      fails     = 0;
      edge_no   = 0;
      next_free = 0;
      last_val  = '0;
      ovf_m     = 1'b0;
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      exp_data  = '0;
      test_reset();
      test_single_vector();
      test_back_to_back();
      test_overflow();
      test_simultaneous();
      test_reset_mid_stream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
